// File: rtl/ps2_key_decoder_if.sv
// Byte-stream and game-control signals between the PS/2 controller side
// (master) and the set-2 scancode decoder (slave).
interface ps2_key_decoder_if;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       clear_keys;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_ext;
    logic       event_break;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic       start_pulse;
    logic       esc_pulse;

    modport master (
        output received_data, received_data_en, clear_keys,
        input  event_valid, event_code, event_ext, event_break,
        input  p1_up, p1_down, p2_up, p2_down, start_pulse, esc_pulse
    );

    modport slave (
        input  received_data, received_data_en, clear_keys,
        output event_valid, event_code, event_ext, event_break,
        output p1_up, p1_down, p2_up, p2_down, start_pulse, esc_pulse
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode parser (E0/F0 prefixes, E1 Pause skip) that tracks the
// Pong control keys and drives paddle levels, start/esc pulses and key events.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    ps2_key_decoder_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_SKIP    = 3'd4;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;

    localparam logic [7:0] K_W     = 8'h1D;
    localparam logic [7:0] K_S     = 8'h1B;
    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_SPACE = 8'h29;
    localparam logic [7:0] K_ESC   = 8'h76;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_skip;
    logic             r_w, r_s, r_up, r_down, r_space, r_esc;
    logic             r_event_valid;
    logic [7:0]       r_event_code;
    logic             r_event_ext;
    logic             r_event_break;
    logic             r_start_pulse;
    logic             r_esc_pulse;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_skip_nxt;
    logic             w_ev;
    logic             w_ev_ext;
    logic             w_ev_brk;
    logic             w_silent;
    logic [7:0]       w_byte;

    assign w_byte   = bus.received_data;
    assign w_silent = w_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_skip_nxt  = r_skip;
        w_ev        = 1'b0;
        w_ev_ext    = 1'b0;
        w_ev_brk    = 1'b0;

        if (bus.clear_keys) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_skip_nxt  = '0;
        end else if (bus.received_data_en) begin
            // A byte arriving on the expiry cycle is still parsed in the current state.
            w_cnt_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (w_byte == B_E0) begin
                        w_state_nxt = S_EXT;
                    end else if (w_byte == B_F0) begin
                        w_state_nxt = S_BRK;
                    end else if (w_byte == B_E1) begin
                        w_state_nxt = S_SKIP;
                        w_skip_nxt  = 3'd7;
                    end else if (!w_silent) begin
                        w_ev = 1'b1;
                    end
                end
                S_EXT: begin
                    if (w_byte == B_F0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (w_byte != B_E0) begin
                        w_ev        = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_ev        = 1'b1;
                    w_ev_brk    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_ev        = 1'b1;
                    w_ev_ext    = 1'b1;
                    w_ev_brk    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_SKIP: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip <= 3'd1) begin
                        w_skip_nxt  = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (r_cnt == CNT_LAST) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_skip_nxt  = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    logic w_hit_w, w_hit_s, w_hit_up, w_hit_down, w_hit_space, w_hit_esc;

    assign w_hit_w     = w_ev && (w_byte == K_W)     && !w_ev_ext;
    assign w_hit_s     = w_ev && (w_byte == K_S)     && !w_ev_ext;
    assign w_hit_up    = w_ev && (w_byte == K_UP)    &&  w_ev_ext;
    assign w_hit_down  = w_ev && (w_byte == K_DOWN)  &&  w_ev_ext;
    assign w_hit_space = w_ev && (w_byte == K_SPACE) && !w_ev_ext;
    assign w_hit_esc   = w_ev && (w_byte == K_ESC)   && !w_ev_ext;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_skip        <= '0;
            r_w           <= 1'b0;
            r_s           <= 1'b0;
            r_up          <= 1'b0;
            r_down        <= 1'b0;
            r_space       <= 1'b0;
            r_esc         <= 1'b0;
            r_event_valid <= 1'b0;
            r_event_code  <= '0;
            r_event_ext   <= 1'b0;
            r_event_break <= 1'b0;
            r_start_pulse <= 1'b0;
            r_esc_pulse   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_skip        <= w_skip_nxt;
            r_event_valid <= w_ev;
            if (w_ev) begin
                r_event_code  <= w_byte;
                r_event_ext   <= w_ev_ext;
                r_event_break <= w_ev_brk;
            end
            // Pulses fire only on the released-to-held edge, so auto-repeat is ignored.
            r_start_pulse <= w_hit_space && !w_ev_brk && !r_space;
            r_esc_pulse   <= w_hit_esc   && !w_ev_brk && !r_esc;

            if (bus.clear_keys) begin
                r_w     <= 1'b0;
                r_s     <= 1'b0;
                r_up    <= 1'b0;
                r_down  <= 1'b0;
                r_space <= 1'b0;
                r_esc   <= 1'b0;
            end else begin
                if (w_hit_w)     r_w     <= !w_ev_brk;
                if (w_hit_s)     r_s     <= !w_ev_brk;
                if (w_hit_up)    r_up    <= !w_ev_brk;
                if (w_hit_down)  r_down  <= !w_ev_brk;
                if (w_hit_space) r_space <= !w_ev_brk;
                if (w_hit_esc)   r_esc   <= !w_ev_brk;
            end
        end
    end

    assign bus.event_valid = r_event_valid;
    assign bus.event_code  = r_event_code;
    assign bus.event_ext   = r_event_ext;
    assign bus.event_break = r_event_break;
    assign bus.start_pulse = r_start_pulse;
    assign bus.esc_pulse   = r_esc_pulse;
    assign bus.p1_up       = r_w    & ~r_s;
    assign bus.p1_down     = r_s    & ~r_w;
    assign bus.p2_up       = r_up   & ~r_down;
    assign bus.p2_down     = r_down & ~r_up;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 controller. Consumes its received_data / received_data_en byte stream.
- Parses PS/2 set-2 keyboard scancodes: E0 extended prefix, F0 break prefix, and the 8-byte E1 Pause sequence.
- Maintains held-key state for the Pong control keys: W, S, Up, Down, Space, Esc.
- Emits paddle move levels, a start pulse and a generic key-event strobe to the game logic.

Parameters:
- TIMEOUT_CYCLES, 100000: idle cycles (2 ms at 50 MHz) after a prefix byte before the parser abandons the partial sequence and returns to IDLE.
- CNT_W, 17: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- resetn  input  1  asynchronous reset, active-low.
- received_data  input  8  byte from the PS/2 controller.
- received_data_en  input  1  one-cycle strobe; received_data is valid this cycle.
- clear_keys  input  1  synchronous; forces all keys released and the parser to IDLE.
- event_valid  output  1  one-cycle pulse when a complete make or break code is decoded.
- event_code  output  8  final code byte of the event.
- event_ext  output  1  event was E0-prefixed.
- event_break  output  1  event was a break (F0-prefixed).
- p1_up  output  1  W held and S not held.
- p1_down  output  1  S held and W not held.
- p2_up  output  1  Up held and Down not held.
- p2_down  output  1  Down held and Up not held.
- start_pulse  output  1  one-cycle pulse on a Space press.
- esc_pulse  output  1  one-cycle pulse on an Esc press.

Behaviour:
- Reset (resetn low, asynchronous):
  - FSM in IDLE; all key-held registers 0; timeout counter 0; skip counter 0.
  - event_valid, event_code, event_ext, event_break, start_pulse and esc_pulse all 0.
  - The four move outputs are therefore 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (inside E1 sequence).
- IDLE, on a strobe:
  - E0 -> EXT; F0 -> BRK.
  - E1 -> SKIP, skip counter = 7.
  - AA, FA, EE, FE, 00 and FF are consumed silently and the FSM stays in IDLE.
  - Any other byte is a make code: raise an event with ext=0, brk=0.
- EXT, on a strobe:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Other byte: make event with ext=1, then -> IDLE.
- BRK, on a strobe: any byte gives a break event with ext=0, then -> IDLE.
- EXT_BRK, on a strobe: any byte gives a break event with ext=1, then -> IDLE.
- SKIP: decrement the skip counter on each strobe; leave for IDLE after the strobe that takes it from 1 to 0. No events are raised from SKIP.
- Timeout:
  - In EXT, BRK, EXT_BRK and SKIP the counter increments each cycle with no strobe and clears on every strobe.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and no event is raised.
  - A strobe in the same cycle as expiry wins: the byte is processed in the current state.
  - The counter is held at 0 in IDLE.
- Latency: for a strobe at cycle N, event_valid/code/ext/break, the key-held registers and the pulses are registered and valid at N+1. The move outputs are combinational from the key-held registers, so they also change at N+1. event_valid stays high for exactly one cycle.
- Key map (key-held register set on make, cleared on break):
  - W = 1D, ext=0.
  - S = 1B, ext=0.
  - Up = 75, ext=1.
  - Down = 72, ext=1.
  - Space = 29, ext=0.
  - Esc = 76, ext=0.
- The ext flag must match: a 75 without E0 (keypad 8) does not affect Up.
- Auto-repeat: repeated make codes for a held key raise event_valid every time. start_pulse and esc_pulse fire only when the held register goes 0->1, so there is one pulse per physical press.
- clear_keys:
  - Has priority over a simultaneous strobe; that byte is dropped.
  - Clears all held registers and returns the FSM to IDLE.
  - Clears the timeout and skip counters.
  - Raises no event and no pulse.
- Both keys of a pair held: both move outputs for that paddle are 0.

Test Plan:
- Reset released, strobe 1D -> at N+1: event_valid=1, event_code=1D, ext=0, break=0; p1_up=1 from then on. Then strobe F0, 1D -> p1_up=0 one cycle after the 1D strobe, and event_break=1 on that event.
- Strobes E0, 75 -> p2_up=1 with event_ext=1. Then 75 with no E0 -> event raised with ext=0, p2_up unchanged. Then E0, F0, 75 -> p2_up=0.
- Strobes 29, 29, 29 (auto-repeat) -> three event_valid pulses, exactly one start_pulse. Then F0, 29, 29 -> a second start_pulse on the final 29.
- Strobes E1, 14, 77, E1, F0, 14, F0, 77 -> no event_valid, no held-key change. A following 1B sets S held (p1_down=1).
- Strobe E0, then 100000 cycles idle -> FSM in IDLE. Then strobe 72 -> event with ext=0 and Down not set. Repeat with the strobe on cycle 99999 -> ext=1 and Down set.
- W and S held -> p1_up=0, p1_down=0. Assert clear_keys in the same cycle as a 76 strobe -> all held registers 0, no esc_pulse, no event. Then pulse resetn low mid-sequence after E0 -> all outputs 0 immediately, and the next byte parses from IDLE.
